// File: rtl/risk_state_lookup.sv
// Pre-trade risk front end: holds the per-client limit table, snapshots a
// client's record for the risk checker and commits passed amounts into exposure.
module risk_state_lookup #(
    parameter int CLIENT_W = 6,
    parameter int AMT_W    = 33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CLIENT_W-1:0] req_client_id,
    input  logic [AMT_W-1:0]    req_amount,
    output logic                chk_valid,
    input  logic                chk_ready,
    output logic [CLIENT_W-1:0] chk_client_id,
    output logic [AMT_W-1:0]    chk_amount,
    output logic [AMT_W-1:0]    chk_max,
    output logic [AMT_W-1:0]    chk_accumulated,
    output logic [AMT_W-1:0]    chk_reduced,
    input  logic                res_valid,
    input  logic                res_pass,
    input  logic                cfg_we,
    input  logic [CLIENT_W-1:0] cfg_client_id,
    input  logic [AMT_W-1:0]    cfg_max,
    input  logic                red_valid,
    input  logic [CLIENT_W-1:0] red_client_id,
    input  logic [AMT_W-1:0]    red_amount,
    output logic                done_valid,
    output logic                done_pass,
    output logic                busy
);

    localparam int DEPTH = 2 ** CLIENT_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        PRESENT,
        WAIT_RES,
        UPDATE
    } state_t;

    state_t state, state_nxt;

    logic [AMT_W-1:0] max_tbl [DEPTH];
    logic [AMT_W-1:0] acc_tbl [DEPTH];
    logic [AMT_W-1:0] red_tbl [DEPTH];

    logic pass_q;
    logic stale_q;
    logic req_fire;
    logic commit;

    function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                                 input logic [AMT_W-1:0] b);
        logic [AMT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[AMT_W] ? '1 : sum[AMT_W-1:0];
    endfunction

    assign req_fire = req_valid && (state == IDLE);
    assign commit   = (state == UPDATE) && pass_q && !stale_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (req_valid) state_nxt = READ;
            READ:     state_nxt = PRESENT;
            PRESENT:  if (chk_ready) state_nxt = WAIT_RES;
            WAIT_RES: if (res_valid) state_nxt = UPDATE;
            UPDATE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        chk_valid  = (state == PRESENT);
        busy       = (state != IDLE);
        done_valid = (state == UPDATE);
        done_pass  = (state == UPDATE) && pass_q;
    end

    // NOTE: the limit table lives in flops rather than RAM because reset must
    // clear every entry so a fresh client has max=0 and fails any real order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                max_tbl[i] <= '0;
                acc_tbl[i] <= '0;
                red_tbl[i] <= '0;
            end
        end else begin
            if (commit)
                acc_tbl[chk_client_id] <= sat_add(acc_tbl[chk_client_id], chk_amount);
            if (red_valid)
                red_tbl[red_client_id] <= sat_add(red_tbl[red_client_id], red_amount);
            // Placed last so a host write overrides commit/reduction to the same client.
            if (cfg_we) begin
                max_tbl[cfg_client_id] <= cfg_max;
                acc_tbl[cfg_client_id] <= '0;
                red_tbl[cfg_client_id] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_client_id   <= '0;
            chk_amount      <= '0;
            chk_max         <= '0;
            chk_accumulated <= '0;
            chk_reduced     <= '0;
            pass_q          <= 1'b0;
            stale_q         <= 1'b0;
        end else begin
            if (req_fire) begin
                chk_client_id <= req_client_id;
                chk_amount    <= req_amount;
                stale_q       <= 1'b0;
            end else if (state != IDLE && cfg_we && cfg_client_id == chk_client_id) begin
                // A host rewrite during flight invalidates the pending commit.
                stale_q <= 1'b1;
            end
            if (state == READ) begin
                chk_max         <= max_tbl[chk_client_id];
                chk_accumulated <= acc_tbl[chk_client_id];
                chk_reduced     <= red_tbl[chk_client_id];
            end
            if (state == WAIT_RES && res_valid)
                pass_q <= res_pass;
        end
    end

endmodule

// File: tb/tb_risk_state_lookup.sv
// Directed bench for risk_state_lookup: expected checker records and verdicts
// are queued by the stimulus and compared by an independent monitor.
module tb_risk_state_lookup;

    localparam int CLIENT_W = 6;
    localparam int AMT_W    = 33;
    localparam logic [AMT_W-1:0] AMAX = '1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [CLIENT_W-1:0] req_client_id;
    logic [AMT_W-1:0]    req_amount;
    logic                chk_valid;
    logic                chk_ready;
    logic [CLIENT_W-1:0] chk_client_id;
    logic [AMT_W-1:0]    chk_amount;
    logic [AMT_W-1:0]    chk_max;
    logic [AMT_W-1:0]    chk_accumulated;
    logic [AMT_W-1:0]    chk_reduced;
    logic                res_valid;
    logic                res_pass;
    logic                cfg_we;
    logic [CLIENT_W-1:0] cfg_client_id;
    logic [AMT_W-1:0]    cfg_max;
    logic                red_valid;
    logic [CLIENT_W-1:0] red_client_id;
    logic [AMT_W-1:0]    red_amount;
    logic                done_valid;
    logic                done_pass;
    logic                busy;

    risk_state_lookup #(.CLIENT_W(CLIENT_W), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_client_id(req_client_id), .req_amount(req_amount),
        .chk_valid(chk_valid), .chk_ready(chk_ready),
        .chk_client_id(chk_client_id), .chk_amount(chk_amount),
        .chk_max(chk_max), .chk_accumulated(chk_accumulated), .chk_reduced(chk_reduced),
        .res_valid(res_valid), .res_pass(res_pass),
        .cfg_we(cfg_we), .cfg_client_id(cfg_client_id), .cfg_max(cfg_max),
        .red_valid(red_valid), .red_client_id(red_client_id), .red_amount(red_amount),
        .done_valid(done_valid), .done_pass(done_pass), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CLIENT_W-1:0] id;
        logic [AMT_W-1:0]    amt;
        logic [AMT_W-1:0]    mx;
        logic [AMT_W-1:0]    acc;
        logic [AMT_W-1:0]    red;
    } chk_t;

    chk_t exp_chk[$];
    bit   exp_done[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_valid && chk_ready) begin
            if (exp_chk.size() == 0) begin
                check("unexpected_chk", 1, 0);
            end else begin
                chk_t e;
                e = exp_chk.pop_front();
                check("chk_client_id",   64'(chk_client_id),   64'(e.id));
                check("chk_amount",      64'(chk_amount),      64'(e.amt));
                check("chk_max",         64'(chk_max),         64'(e.mx));
                check("chk_accumulated", 64'(chk_accumulated), 64'(e.acc));
                check("chk_reduced",     64'(chk_reduced),     64'(e.red));
            end
        end
        if (done_valid) begin
            if (exp_done.size() == 0) check("unexpected_done", 1, 0);
            else                      check("done_pass", 64'(done_pass), 64'(exp_done.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_chk(input logic [CLIENT_W-1:0] id, input logic [AMT_W-1:0] amt,
                              input logic [AMT_W-1:0] mx, input logic [AMT_W-1:0] acc,
                              input logic [AMT_W-1:0] red);
        chk_t e;
        e.id = id; e.amt = amt; e.mx = mx; e.acc = acc; e.red = red;
        exp_chk.push_back(e);
    endtask

    task automatic do_cfg(input logic [CLIENT_W-1:0] id, input logic [AMT_W-1:0] mx);
        cfg_we = 1'b1; cfg_client_id = id; cfg_max = mx;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_red(input logic [CLIENT_W-1:0] id, input logic [AMT_W-1:0] amt);
        red_valid = 1'b1; red_client_id = id; red_amount = amt;
        tick();
        red_valid = 1'b0;
    endtask

    // Handshake a request from IDLE and return once the DUT is in PRESENT.
    task automatic start_req(input logic [CLIENT_W-1:0] id, input logic [AMT_W-1:0] amt);
        int n;
        req_valid = 1'b1; req_client_id = id; req_amount = amt;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!chk_valid && n < 20) begin
            tick();
            n++;
        end
        if (!chk_valid) check("chk_valid_timeout", 0, 1);
    endtask

    task automatic accept_chk();
        chk_ready = 1'b1;
        tick();
        chk_ready = 1'b0;
    endtask

    task automatic give_res(input bit pass);
        exp_done.push_back(pass);
        res_valid = 1'b1; res_pass = pass;
        tick();
        res_valid = 1'b0; res_pass = 1'b0;
        tick();
    endtask

    task automatic full_req(input logic [CLIENT_W-1:0] id, input logic [AMT_W-1:0] amt,
                            input logic [AMT_W-1:0] mx, input logic [AMT_W-1:0] acc,
                            input logic [AMT_W-1:0] red, input bit pass);
        expect_chk(id, amt, mx, acc, red);
        start_req(id, amt);
        accept_chk();
        give_res(pass);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_client_id = '0; req_amount = '0;
        chk_ready = 0; res_valid = 0; res_pass = 0;
        cfg_we = 0; cfg_client_id = '0; cfg_max = '0;
        red_valid = 0; red_client_id = '0; red_amount = '0;
        tick();
        tick();
        check("rst_req_ready",  64'(req_ready),  1);
        check("rst_busy",       64'(busy),       0);
        check("rst_chk_valid",  64'(chk_valid),  0);
        check("rst_done_valid", 64'(done_valid), 0);
        check("rst_chk_max",    64'(chk_max),    0);
        rst_n = 1'b1;
        tick();

        // Basic pass, then accumulated visible to the next request.
        do_cfg(3, 1000);
        full_req(3, 400, 1000, 0, 0, 1'b1);
        full_req(3, 250, 1000, 400, 0, 1'b0);
        // Fail path leaves exposure untouched.
        full_req(3, 700, 1000, 400, 0, 1'b0);
        full_req(3, 10, 1000, 400, 0, 1'b0);

        // Reduction visibility: IDLE reduction shown, PRESENT reduction not.
        do_red(3, 300);
        expect_chk(3, 100, 1000, 400, 300);
        start_req(3, 100);
        do_red(3, 50);
        check("present_chk_reduced", 64'(chk_reduced), 300);
        accept_chk();
        give_res(1'b1);
        full_req(3, 1, 1000, 500, 350, 1'b0);

        // Stale config: host rewrite during WAIT_RES suppresses the commit.
        do_cfg(5, 100);
        expect_chk(5, 50, 100, 0, 0);
        start_req(5, 50);
        accept_chk();
        do_cfg(5, 200);
        give_res(1'b1);
        full_req(5, 1, 200, 0, 0, 1'b0);

        // Saturation and backpressure; res_valid outside WAIT_RES is ignored.
        do_cfg(7, AMAX);
        full_req(7, AMAX - 99, AMAX, 0, 0, 1'b1);
        expect_chk(7, 1000, AMAX, AMAX - 99, 0);
        start_req(7, 1000);
        res_valid = 1'b1; res_pass = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_req_ready",  64'(req_ready),       0);
            check("bp_chk_valid",  64'(chk_valid),       1);
            check("bp_chk_amount", 64'(chk_amount),      1000);
            check("bp_chk_acc",    64'(chk_accumulated), 64'(AMAX - 99));
            tick();
        end
        res_valid = 1'b0;
        accept_chk();
        give_res(1'b1);
        do_red(7, AMAX);
        do_red(7, AMAX);
        full_req(7, 1, AMAX, AMAX, AMAX, 1'b0);

        // Reset mid-flight in WAIT_RES: no done pulse, table cleared.
        do_cfg(9, 500);
        expect_chk(9, 10, 500, 0, 0);
        start_req(9, 10);
        accept_chk();
        check("pre_rst_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 1);
        check("mid_rst_busy",      64'(busy),      0);
        check("mid_rst_chk_amt",   64'(chk_amount), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done_valid", 64'(done_valid), 0);
        full_req(9, 10, 0, 0, 0, 1'b0);
        full_req(3, 5, 0, 0, 0, 1'b0);

        tick();
        check("chk_queue_empty",  64'(exp_chk.size()),  0);
        check("done_queue_empty", 64'(exp_done.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
